// File: rtl/multiport_register_file_pkg.sv
// Shared types and helpers for the multi-port register file: FSM state encoding,
// a zero word and the flattened-bus slice offset helper.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] WORD_ZERO = '0;

    // Low bit index of element idx inside a flattened bus of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/multiport_register_file_if.sv
// Bundles the read/write ports and the ready flag of the register file.
// The slave side is the register file; the master side is the datapath.
interface multiport_register_file_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic                     ready;
    logic [NUM_WR-1:0]        we;
    logic [NUM_WR*ADDR_W-1:0] waddr;
    logic [NUM_WR*DATA_W-1:0] wdata;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;

    modport master (input ready, rdata, output we, waddr, wdata, raddr);
    modport slave  (output ready, rdata, input we, waddr, wdata, raddr);
endinterface

// File: rtl/multiport_register_file_clear_fsm.sv
// Post-reset clear sequencer: walks every entry once, emitting one clear
// strobe per edge, then raises ready until the next reset.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready_o,
    output logic              clr_en_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_en_o  = 1'b0;
        if (state_q == ST_CLEAR) begin
            // Reset has priority: no clear strobe on an edge where rst_n is low.
            clr_en_o  = rst_n;
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                state_d = ST_READY;
            end
        end
    end

    assign ready_o    = (state_q == ST_READY);
    assign clr_addr_o = clr_ptr_q;

endmodule

// File: rtl/multiport_register_file.sv
// Parametrised N-read / M-write register file with post-reset clear and optional
// hardwired-zero entry 0. Define REGFILE_BYPASS_EN to forward same-cycle write data.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input logic                       clk,
    input logic                       rst_n,
    multiport_register_file_if.slave  rf
);

    localparam logic [DATA_W-1:0] ZERO_WORD = DATA_W'(WORD_ZERO);

    logic              ready;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    regfile_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .ready_o    (ready),
        .clr_en_o   (clr_en),
        .clr_addr_o (clr_addr)
    );

    assign rf.ready = ready;
    assign wr_ok    = ready && rst_n;

    // Ports are applied in ascending order so the highest-index port wins a collision.
    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_addr] = ZERO_WORD;
        end else if (wr_ok) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (rf.we[p]) begin
                    mem_d[rf.waddr[slice_lo(p, ADDR_W) +: ADDR_W]] =
                        rf.wdata[slice_lo(p, DATA_W) +: DATA_W];
                end
            end
        end
        if (ZERO_REG != 0) begin
            mem_d[0] = ZERO_WORD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            mem_q <= mem_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rd_val;

            assign ra = rf.raddr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                rd_val = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < NUM_WR; p++) begin
                    if (ready && rf.we[p] && (rf.waddr[slice_lo(p, ADDR_W) +: ADDR_W] == ra)) begin
                        rd_val = rf.wdata[slice_lo(p, DATA_W) +: DATA_W];
                    end
                end
`endif
                if (!ready || ((ZERO_REG != 0) && (ra == '0))) begin
                    rd_val = ZERO_WORD;
                end
            end

            assign rf.rdata[gi*DATA_W +: DATA_W] = rd_val;
        end
    endgenerate

endmodule

// File: tb/tb_multiport_register_file.sv
// Randomised + directed bench for multiport_register_file against a behavioural
// model of the clear-then-ready register file, checked every cycle.
module tb_multiport_register_file;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    // Behavioural model: entries, edges seen since reset release, ready flag.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_cnt = 0;
    bit            m_ready = 1'b0;

    multiport_register_file_if #(
        .DATA_W (DW), .DEPTH (DEPTH), .NUM_RD (NR), .NUM_WR (NW)
    ) rf_if ();

    multiport_register_file #(
        .DATA_W (DW), .DEPTH (DEPTH), .NUM_RD (NR), .NUM_WR (NW), .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_if)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input int a);
        logic [DW-1:0] v;
        if (!m_ready) return '0;
        if (a == 0) return '0;
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NW; p++)
            if (rf_if.we[p] && int'(rf_if.waddr[p*AW +: AW]) == a)
                v = rf_if.wdata[p*DW +: DW];
`endif
        return v;
    endfunction

    task automatic m_update();
        if (!rst_n) begin
            m_cnt = 0;
        end else if (m_cnt < DEPTH) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
        end else begin
            for (int p = 0; p < NW; p++)
                if (rf_if.we[p]) m_mem[int'(rf_if.waddr[p*AW +: AW])] = rf_if.wdata[p*DW +: DW];
        end
        m_ready = (m_cnt == DEPTH);
    endtask

    // One clock edge: update the model at the edge, compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rf_if.we != '0)
            $display("edge rst_n=%0b we=%b waddr=%h wdata=%h", rst_n, rf_if.we, rf_if.waddr, rf_if.wdata);
        m_update();
        @(negedge clk);
        chk("ready", DW'(rf_if.ready), DW'(m_ready));
        for (int r = 0; r < NR; r++)
            chk($sformatf("rdata%0d", r), rf_if.rdata[r*DW +: DW], m_read(int'(rf_if.raddr[r*AW +: AW])));
    endtask

    task automatic idle_inputs();
        rf_if.we    = '0;
        rf_if.waddr = '0;
        rf_if.wdata = '0;
    endtask

    task automatic set_wr(input int p, input int addr, input logic [DW-1:0] data);
        rf_if.we[p]             = 1'b1;
        rf_if.waddr[p*AW +: AW] = AW'(addr);
        rf_if.wdata[p*DW +: DW] = data;
    endtask

    task automatic set_rd(input int r, input int addr);
        rf_if.raddr[r*AW +: AW] = AW'(addr);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!rf_if.ready && n < 100) begin
            cycle();
            n++;
        end
    endtask

    task automatic fill_deadbeef();
        for (int a = 0; a < DEPTH; a += 2) begin
            idle_inputs();
            set_wr(0, a, 32'hDEADBEEF);
            set_wr(1, a + 1, 32'hDEADBEEF);
            cycle();
        end
        idle_inputs();
        set_rd(0, 4);
        set_rd(1, 31);
        cycle();
        chk("fill_addr4", rf_if.rdata[0 +: DW], 32'hDEADBEEF);
        chk("fill_addr31", rf_if.rdata[DW +: DW], 32'hDEADBEEF);
    endtask

    task automatic sweep_zero(input string tag);
        idle_inputs();
        for (int a = 0; a < DEPTH; a += 2) begin
            set_rd(0, a);
            set_rd(1, a + 1);
            cycle();
            chk($sformatf("%s_a%0d", tag, a), rf_if.rdata[0 +: DW], 32'h0);
            chk($sformatf("%s_a%0d", tag, a + 1), rf_if.rdata[DW +: DW], 32'h0);
        end
    endtask

    initial begin
        int n;
        idle_inputs();
        rf_if.raddr = '0;

        // Initial reset and clear sequence.
        rst_n = 1'b0;
        repeat (2) cycle();
        chk("reset_ready", DW'(rf_if.ready), 32'h0);
        rst_n = 1'b1;
        wait_ready(n);
        chk("ready_latency_init", DW'(n), 32'd32);

        // Fill, reset, and make sure writes issued during CLEAR are ignored.
        fill_deadbeef();
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        set_wr(0, 3, 32'hAAAA5555);
        wait_ready(n);
        idle_inputs();
        chk("ready_latency_fill", DW'(n), 32'd32);
        sweep_zero("clr");

        // Reset in the middle of the clear sequence restarts it.
        fill_deadbeef();
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (10) cycle();
        chk("midclear_ready", DW'(rf_if.ready), 32'h0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        wait_ready(n);
        chk("ready_latency_restart", DW'(n), 32'd32);
        sweep_zero("restart");

        // Directed writes on each port.
        idle_inputs();
        set_wr(0, 5, 32'h0000FFFF);
        cycle();
        idle_inputs();
        set_wr(1, 30, 32'hFFFF0000);
        cycle();
        idle_inputs();
        set_rd(0, 5);
        set_rd(1, 30);
        cycle();
        chk("port0_addr5", rf_if.rdata[0 +: DW], 32'h0000FFFF);
        chk("port1_addr30", rf_if.rdata[DW +: DW], 32'hFFFF0000);

        // Same-edge collision: port 1 wins.
        set_wr(0, 7, 32'h11111111);
        set_wr(1, 7, 32'h22222222);
        cycle();
        idle_inputs();
        set_rd(0, 7);
        cycle();
        chk("collision_addr7", rf_if.rdata[0 +: DW], 32'h22222222);

        // Writes to the zero register are dropped.
        set_wr(0, 0, 32'h12345678);
        set_wr(1, 0, 32'h9ABCDEF0);
        cycle();
        idle_inputs();
        set_rd(0, 0);
        set_rd(1, 0);
        cycle();
        chk("zero_reg_p0", rf_if.rdata[0 +: DW], 32'h0);
        chk("zero_reg_p1", rf_if.rdata[DW +: DW], 32'h0);

        // Same-cycle read of a location being written.
        set_wr(0, 9, 32'h00000009);
        cycle();
        idle_inputs();
        set_wr(0, 9, 32'hCAFEF00D);
        set_rd(0, 9);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_same_cycle", rf_if.rdata[0 +: DW], 32'hCAFEF00D);
`else
        chk("no_bypass_same_cycle", rf_if.rdata[0 +: DW], 32'h00000009);
`endif
        cycle();
        idle_inputs();
        cycle();
        chk("after_edge_addr9", rf_if.rdata[0 +: DW], 32'hCAFEF00D);

        // Randomised traffic with narrow address ranges to provoke collisions and occasional resets.
        for (int i = 0; i < 400; i++) begin
            int span;
            span = ($urandom_range(0, 1) == 0) ? 7 : DEPTH - 1;
            rst_n = ($urandom_range(0, 149) != 0);
            rf_if.we = NW'($urandom_range(0, 3));
            for (int p = 0; p < NW; p++) begin
                rf_if.waddr[p*AW +: AW] = AW'($urandom_range(0, span));
                rf_if.wdata[p*DW +: DW] = $urandom;
            end
            for (int r = 0; r < NR; r++)
                set_rd(r, $urandom_range(0, span));
            cycle();
        end
        rst_n = 1'b1;
        idle_inputs();
        wait_ready(n);
        chk("ready_final", DW'(rf_if.ready), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
